generateur_tirage: RTL
======================

// Module: generateur_tirage
// PURPOSE
//  Producer side of the draw interface: drives the free-running modulo count CntModuloReg
//  and the TriggerTirage edge consumed by the downstream draw sampler. Synchronises and
//  debounces the player button, freezes the count around each trigger edge, and skips
//  already-drawn values so a game of NB_TIRAGES draws yields distinct numbers.
// PARAMETERS
//  MODULO          49  count range 1..MODULO; 2 <= MODULO <= 127
//  NB_TIRAGES      6   draws per game; 1 <= NB_TIRAGES <= 15, NB_TIRAGES < MODULO
//  DEBOUNCE_CYCLES 16  consecutive stable cycles needed to accept a new button level (>=2)
//  POLARITY_TIRAGE 0   0: active edge rising (idle 0); 1: active edge falling (idle 1)
// PORTS
//  Clk           in   1  system clock, all logic on rising edge
//  Reset         in   1  asynchronous, active-high reset
//  BtnTirage     in   1  raw asynchronous push-button, high = pressed
//  NouveauTirage in   1  synchronous 1-cycle pulse: start a new game
//  CntModuloReg  out  7  current count value, always registered
//  TriggerTirage out  1  draw edge to sampler; active edge per POLARITY_TIRAGE
//  Occupe        out  1  high while a draw sequence is in progress
//  TirageFini    out  1  high once NB_TIRAGES draws are done, until NouveauTirage
//  NbTires       out  4  number of draws completed in current game
// BEHAVIOUR
//  Reset: CntModuloReg=1, TriggerTirage=POLARITY_TIRAGE (idle level), Occupe=0,
//   TirageFini=0, NbTires=0, drawn mask cleared, sync/debounce regs 0, pending=0, FSM=IDLE.
//  Input path: BtnTirage -> 2-FF synchroniser -> debouncer; the debounced level changes
//   only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised level.
//   A rising debounced edge raises a 1-cycle request.
//  Request latch: in IDLE, request sets pending. Requests in other states are dropped.
//  Free counter CntLibre: 1,2,..,MODULO,1,... advancing every cycle in IDLE only.
//   Each IDLE cycle, if mask[CntLibre]==0 then CntModuloReg <= CntLibre, else it holds.
//  FSM:
//   IDLE       -> ARME when pending && mask[CntModuloReg]==0 (pending cleared).
//   ARME       1 cycle; CntModuloReg frozen; Occupe=1.
//   IMPULSION  2 cycles; TriggerTirage at active level (edge on entry); frozen.
//   ENREG      1 cycle; trigger back to idle; mask[CntModuloReg]<=1; NbTires+1;
//              -> FINI if new NbTires==NB_TIRAGES, else IDLE.
//   FINI       TirageFini=1; counter frozen; requests ignored.
//  Timing: request at cycle t with valid value -> ARME t+1, active edge t+2,
//   idle level t+4, NbTires updated t+5. CntModuloReg constant from t+1 to t+4 inclusive.
//  Occupe=1 exactly in ARME, IMPULSION, ENREG.
//  Distinctness: the value presented at an active edge is never one already drawn in the game.
//  NouveauTirage (any state, priority over request and pending): next cycle mask=0,
//   NbTires=0, TirageFini=0, pending=0, TriggerTirage=idle, FSM=IDLE. CntModuloReg holds.
//   An aborted IMPULSION may leave a 1-cycle active pulse; this is accepted.
//  Async Reset mid-sequence: all state returns to reset values immediately.
// TESTING
//  1. Reset, MODULO=49: hold idle 60 cycles -> CntModuloReg steps 1..49,1; trigger stays at idle level.
//  2. Press button clean for DEBOUNCE_CYCLES+4 -> exactly one active edge; value stable
//     t+1..t+4; NbTires=1; Occupe high for 4 cycles.
//  3. Bouncy press (toggle every 3 cycles for 40 cycles, then hold) -> one draw only.
//  4. 6 presses -> 6 distinct sampled values; TirageFini=1 after 6th; 7th press -> no edge.
//  5. MODULO=3, NB_TIRAGES=2: draw value 2 -> CntModuloReg never shows 2 again; next draw is 1 or 3.
//  6. NouveauTirage during IMPULSION -> IDLE next cycle, NbTires=0, trigger idle; POLARITY_TIRAGE=1 re-run of test 2.

Source files
------------

// File: rtl/generateur_tirage_if.sv
// Draw interface between the player-side draw generator and the downstream draw sampler.
// The generator is the master: it reads the player inputs and drives the count/trigger side.
interface generateur_tirage_if;
    logic       BtnTirage;
    logic       NouveauTirage;
    logic [6:0] CntModuloReg;
    logic       TriggerTirage;
    logic       Occupe;
    logic       TirageFini;
    logic [3:0] NbTires;

    modport master (
        input  BtnTirage, NouveauTirage,
        output CntModuloReg, TriggerTirage, Occupe, TirageFini, NbTires
    );

    modport slave (
        output BtnTirage, NouveauTirage,
        input  CntModuloReg, TriggerTirage, Occupe, TirageFini, NbTires
    );
endinterface

// File: rtl/generateur_tirage.sv
// Draw generator: debounced player button, free-running modulo count that skips drawn values,
// and a trigger edge sequence that freezes the count while the sampler captures it.
module generateur_tirage #(
    parameter int MODULO          = 49,
    parameter int NB_TIRAGES      = 6,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POLARITY_TIRAGE = 0
) (
    input logic                 Clk,
    input logic                 Reset,
    generateur_tirage_if.master tirage
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ARME      = 3'd1;
    localparam logic [2:0] IMPULSION = 3'd2;
    localparam logic [2:0] ENREG     = 3'd3;
    localparam logic [2:0] FINI      = 3'd4;

    localparam logic TRIG_IDLE = 1'(POLARITY_TIRAGE);

    logic [1:0]    syncReg;
    logic          btnDeb;
    logic          btnDebQ;
    logic [DW-1:0] debCnt;
    logic          req;

    logic [2:0]    state;
    logic          impCnt;
    logic          trigReg;
    logic          pending;
    logic [3:0]    nbTires;
    logic [127:0]  mask;
    logic [6:0]    cntLibre;
    logic [6:0]    cntModuloReg;
    logic          curFree;
    logic          libreFree;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            syncReg <= '0;
            btnDeb  <= 1'b0;
            btnDebQ <= 1'b0;
            debCnt  <= '0;
        end else begin
            syncReg <= {syncReg[0], tirage.BtnTirage};
            btnDebQ <= btnDeb;
            if (syncReg[1] == btnDeb) begin
                debCnt <= '0;
            end else if (debCnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                btnDeb <= syncReg[1];
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + DW'(1);
            end
        end
    end

    assign req       = btnDeb & ~btnDebQ;
    assign curFree   = ~mask[cntModuloReg];
    assign libreFree = ~mask[cntLibre];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            impCnt       <= 1'b0;
            trigReg      <= TRIG_IDLE;
            pending      <= 1'b0;
            nbTires      <= '0;
            mask         <= '0;
            cntLibre     <= 7'd1;
            cntModuloReg <= 7'd1;
        end else if (tirage.NouveauTirage) begin
            state   <= IDLE;
            impCnt  <= 1'b0;
            trigReg <= TRIG_IDLE;
            pending <= 1'b0;
            nbTires <= '0;
            mask    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cntLibre <= (cntLibre == 7'(MODULO)) ? 7'd1 : cntLibre + 7'd1;
                    if (libreFree)
                        cntModuloReg <= cntLibre;
                    // Arm on the request cycle itself so ARME follows one cycle later;
                    // the latch only carries requests that land on an already-drawn value.
                    if ((req || pending) && curFree) begin
                        state   <= ARME;
                        pending <= 1'b0;
                    end else if (req) begin
                        pending <= 1'b1;
                    end
                end
                ARME: begin
                    state   <= IMPULSION;
                    impCnt  <= 1'b0;
                    trigReg <= ~TRIG_IDLE;
                end
                IMPULSION: begin
                    impCnt <= 1'b1;
                    if (impCnt) begin
                        state   <= ENREG;
                        trigReg <= TRIG_IDLE;
                    end
                end
                ENREG: begin
                    mask[cntModuloReg] <= 1'b1;
                    nbTires            <= nbTires + 4'd1;
                    state              <= (nbTires + 4'd1 == 4'(NB_TIRAGES)) ? FINI : IDLE;
                end
                FINI: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tirage.CntModuloReg  = cntModuloReg;
    assign tirage.TriggerTirage = trigReg;
    assign tirage.Occupe        = (state == ARME) || (state == IMPULSION) || (state == ENREG);
    assign tirage.TirageFini    = (state == FINI);
    assign tirage.NbTires       = nbTires;
endmodule
